line_assembler: RTL
===================

// Module: line_assembler
// PURPOSE
//  Parametrised successor of the HID line accumulator. Collects UART RX chars into a
//  line; CR, LF and CRLF terminate it; BS/DEL edit it. Completed lines go to a holding
//  register with a valid/ready handshake, and the next line keeps accumulating meanwhile.
//  Sits between the UART receiver and the paint command parser.
// PARAMETERS
//  MAX_CHARS   16  max payload chars per line (>=2); line_out width = MAX_CHARS*8
//  EMIT_EMPTY  0   1: a bare terminator emits a len-0 line; 0: it is ignored
//  LEN_W       $clog2(MAX_CHARS+1)  width of line_len (derived, do not override)
// PORTS
//  clk            in   1            system clock
//  rst_n          in   1            asynchronous active-low reset
//  rx_char        in   8            received byte
//  rx_valid       in   1            1-cycle strobe, rx_char valid
//  line_out       out  MAX_CHARS*8  char i at [i*8 +: 8]; bytes >= line_len are 0
//  line_len       out  LEN_W        payload chars in line_out
//  line_overflow  out  1            line was truncated (chars beyond MAX_CHARS discarded)
//  line_valid     out  1            holding register full
//  line_ready     in   1            consumer accepts when line_valid & line_ready
//  line_dropped   out  1            1-cycle pulse: completed line lost, holding reg busy
// BEHAVIOUR
//  Reset (async, rst_n=0): acc buffer=0, acc_len=0, acc_ovf=0, state=ACCUM;
//   line_out=0, line_len=0, line_overflow=0, line_valid=0, line_dropped=0.
//  Accumulator FSM (acts only when rx_valid=1):
//   ACCUM  : LF or CR -> terminate; CR -> CR_SEEN, LF -> stay ACCUM.
//            BS(08h)/DEL(7Fh): acc_len>0 -> acc_len-1, zero that byte; acc_len=0 -> ignore.
//            other char: acc_len<MAX_CHARS -> store at acc_len, acc_len+1;
//            else discard and set acc_ovf.
//   CR_SEEN: LF -> swallowed, no terminate, -> ACCUM (CRLF is one terminator).
//            any other byte -> handled exactly as in ACCUM.
//  Terminate: with acc_len=0 and acc_ovf=0 and EMIT_EMPTY=0 -> nothing emitted.
//   Otherwise the line is offered to the holding register in the same cycle. In both
//   cases acc buffer, acc_len and acc_ovf are cleared to 0 on that clock edge.
//  Holding register:
//   - load when a line is offered and (line_valid=0 or line_ready=1); line_valid=1
//     from the next cycle (latency: terminator strobe at edge N -> line_valid after N+1).
//   - offer while line_valid=1 and line_ready=0: line is lost, line_dropped=1 for
//     exactly one cycle, holding register unchanged.
//   - line_valid & line_ready with no offer: line_valid->0; line_out/len/ovf keep values.
//   - line_out, line_len, line_overflow stable whenever line_valid=1.
//  rx_valid while line_valid=1 is always accepted into the accumulator; it never stalls.
//  An overflowed line still reports line_len=MAX_CHARS and keeps the first MAX_CHARS chars.
//  line_ready is ignored while line_valid=0.
// STRUCTURE
//  hid_pkg: ASCII constants CH_LF=8'h0A, CH_CR=8'h0D, CH_BS=8'h08, CH_DEL=8'h7F;
//   FSM state encoding ACC_S_ACCUM/ACC_S_CR_SEEN.
//  Sub-module line_hold_reg (param WIDTH): one-entry valid/ready holding register
//   with load/drop logic; line_assembler holds the FSM, buffer and editing logic.
// TESTING
//  "ABC\n", line_ready=1 -> one line_valid cycle, line_out[23:0]=43_42_41h, len=3, rest 0.
//  "HI\r\n" then "X\r" -> exactly two lines ("HI" len 2, "X" len 1); no empty line.
//  "AB",08h,"C\n" -> line "AC", len=2; 7Fh on an empty line -> ignored, len unchanged.
//  MAX_CHARS=4, "ABCDEF\n" -> len=4 "ABCD", line_overflow=1; next line has overflow=0.
//  line_ready=0, send "A\n","B\n","C\n" -> hold keeps "A"; line_dropped pulses for
//   "B" and again for "C"; raise ready, then "D\n" -> "D" delivered.
//  rst_n low in mid-line "AB" -> all outputs 0 at once; after release "C\n" -> "C", len=1.

Source files
------------

// File: rtl/hid_pkg.sv
// Shared ASCII control codes and accumulator state encoding for the HID line path.
package hid_pkg;

    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_DEL = 8'h7F;

    typedef enum logic {
        ACC_S_ACCUM,
        ACC_S_CR_SEEN
    } acc_state_e;

endpackage

// File: rtl/line_hold_reg.sv
// One-entry valid/ready holding register; an offer that finds it busy is dropped.
module line_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             offer,
    input  logic [WIDTH-1:0] offer_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             dropped
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             dropped_q, dropped_d;
    logic             load;

    // Ready only matters while full, so the slot frees in the same cycle it is reloaded.
    assign load = offer && (!valid_q || ready);

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        dropped_d = offer && valid_q && !ready;
        if (load) begin
            data_d  = offer_data;
            valid_d = 1'b1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            dropped_q <= dropped_d;
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign dropped = dropped_q;

endmodule

// File: rtl/line_assembler.sv
// Accumulates UART bytes into lines with BS/DEL editing and CR/LF/CRLF termination.
module line_assembler
    import hid_pkg::*;
#(
    parameter int MAX_CHARS  = 16,
    parameter int EMIT_EMPTY = 0,
    parameter int LEN_W      = $clog2(MAX_CHARS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_char,
    input  logic                   rx_valid,
    output logic [MAX_CHARS*8-1:0] line_out,
    output logic [LEN_W-1:0]       line_len,
    output logic                   line_overflow,
    output logic                   line_valid,
    input  logic                   line_ready,
    output logic                   line_dropped
);

    localparam int HOLD_W = MAX_CHARS * 8 + LEN_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_CHARS);

    acc_state_e                  state_q, state_d;
    logic [MAX_CHARS-1:0][7:0]   buf_q, buf_d;
    logic [LEN_W-1:0]            len_q, len_d;
    logic                        ovf_q, ovf_d;
    logic                        term;
    logic                        offer;
    logic [HOLD_W-1:0]           hold_data;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        term    = 1'b0;
        if (rx_valid) begin
            if (state_q == ACC_S_CR_SEEN && rx_char == CH_LF) begin
                // Second half of CRLF: the line was already terminated by the CR.
                state_d = ACC_S_ACCUM;
            end else if (rx_char == CH_CR || rx_char == CH_LF) begin
                term    = 1'b1;
                state_d = (rx_char == CH_CR) ? ACC_S_CR_SEEN : ACC_S_ACCUM;
                buf_d   = '0;
                len_d   = '0;
                ovf_d   = 1'b0;
            end else begin
                state_d = ACC_S_ACCUM;
                if (rx_char == CH_BS || rx_char == CH_DEL) begin
                    if (len_q != '0) begin
                        len_d = len_q - 1'b1;
                        for (int i = 0; i < MAX_CHARS; i++) begin
                            if (i == int'(len_q) - 1) buf_d[i] = 8'h00;
                        end
                    end
                end else if (len_q < MAX_LEN) begin
                    len_d = len_q + 1'b1;
                    for (int i = 0; i < MAX_CHARS; i++) begin
                        if (i == int'(len_q)) buf_d[i] = rx_char;
                    end
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    assign offer = term && (len_q != '0 || ovf_q || EMIT_EMPTY != 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC_S_ACCUM;
            buf_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    line_hold_reg #(
        .WIDTH(HOLD_W)
    ) u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .offer      (offer),
        .offer_data ({ovf_q, len_q, buf_q}),
        .ready      (line_ready),
        .data       (hold_data),
        .valid      (line_valid),
        .dropped    (line_dropped)
    );

    assign line_out      = hold_data[MAX_CHARS*8-1:0];
    assign line_len      = hold_data[MAX_CHARS*8 +: LEN_W];
    assign line_overflow = hold_data[HOLD_W-1];

endmodule
